// File: rtl/line_buffer_multi_if.sv
// Pixel stream bundle for line_buffer_multi: stream controls and pixel in, tap column out.
// The master drives the stream; the slave is the line buffer.
interface line_buffer_multi_if #(
  parameter int DWIDTH = 9,
  parameter int AWIDTH = 11,
  parameter int LINES  = 2
);
  logic                         clken;
  logic                         sof;
  logic                         enable;
  logic [AWIDTH-1:0]            width;
  logic [DWIDTH-1:0]            din;
  logic [DWIDTH*(LINES+1)-1:0]  dout;
  logic [AWIDTH-1:0]            col;
  logic                         eol;
  logic                         valid;

  modport master (
    output clken, sof, enable, width, din,
    input  dout, col, eol, valid
  );

  modport slave (
    input  clken, sof, enable, width, din,
    output dout, col, eol, valid
  );
endinterface

// File: rtl/line_buffer_multi.sv
// N-line delay buffer: each accepted pixel yields a column of LINES+1 vertical taps.
// Optional macro LB_BORDER_REPLICATE_EN: unfilled taps copy the nearest real row and valid follows enable.
module line_buffer_multi #(
  parameter int DWIDTH = 9,
  parameter int AWIDTH = 11,
  parameter int WORDS  = 1920,
  parameter int LINES  = 2
) (
  input logic                clk,
  input logic                rst,
  line_buffer_multi_if.slave bus
);
  localparam int TAPS = LINES + 1;
  localparam int RFW  = $clog2(LINES + 1);
  localparam logic [AWIDTH-1:0] WORDS_A = AWIDTH'(WORDS);
  localparam logic [RFW-1:0]    FULL    = RFW'(LINES);

  function automatic logic [AWIDTH-1:0] clamp_width(input logic [AWIDTH-1:0] w);
    logic [AWIDTH-1:0] r;
    r = w;
    if (w == '0)
      r = AWIDTH'(1);
    else if (w > WORDS_A)
      r = WORDS_A;
    return r;
  endfunction

  logic [DWIDTH-1:0]      mem [LINES][WORDS];
  logic [AWIDTH-1:0]      width_q;
  logic [AWIDTH-1:0]      wr_col;
  logic [RFW-1:0]         row_fill;
  logic                   load_pend;

  logic [AWIDTH-1:0]      cur_width;
  logic [AWIDTH-1:0]      cur_col;
  logic [RFW-1:0]         cur_fill;
  logic                   last;
  logic [DWIDTH-1:0]      real_tap [TAPS];
  logic [DWIDTH-1:0]      tap_sel  [TAPS];
  logic [DWIDTH*TAPS-1:0] tap_pack;
  logic                   valid_nxt;

  logic [DWIDTH*TAPS-1:0] tap_p1;
  logic [AWIDTH-1:0]      col_p1;
  logic                   eol_p1;
  logic                   vld_p1;

  // Stage 0: an sof pixel (or the first edge after reset) sees the freshly sampled width.
  always_comb begin
    cur_width = (bus.sof || load_pend) ? clamp_width(bus.width) : width_q;
    cur_col   = bus.sof ? '0 : wr_col;
    cur_fill  = bus.sof ? '0 : row_fill;
    last      = (cur_col == cur_width - AWIDTH'(1));

    real_tap[0] = bus.din;
    for (int k = 1; k < TAPS; k++)
      real_tap[k] = mem[k-1][cur_col];

    for (int k = 0; k < TAPS; k++) begin
      if (RFW'(k) <= cur_fill)
        tap_sel[k] = real_tap[k];
      else
`ifdef LB_BORDER_REPLICATE_EN
        tap_sel[k] = real_tap[cur_fill];
`else
        tap_sel[k] = '0;
`endif
    end

    tap_pack = '0;
    for (int k = 0; k < TAPS; k++)
      tap_pack[k*DWIDTH +: DWIDTH] = tap_sel[k];

`ifdef LB_BORDER_REPLICATE_EN
    valid_nxt = bus.enable;
`else
    valid_nxt = bus.enable && (cur_fill == FULL);
`endif
  end

  // Line storage cascades one row down per accept at the current column; never reset.
  always_ff @(posedge clk) begin
    if (bus.clken) begin
      mem[0][cur_col] <= bus.din;
      for (int k = 1; k < LINES; k++)
        mem[k][cur_col] <= mem[k-1][cur_col];
    end
  end

  // Stage 1: registered tap column and position/fill tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      width_q   <= WORDS_A;
      load_pend <= 1'b1;
      wr_col    <= '0;
      row_fill  <= '0;
      tap_p1    <= '0;
      col_p1    <= '0;
      eol_p1    <= 1'b0;
      vld_p1    <= 1'b0;
    end else begin
      load_pend <= 1'b0;
      if (load_pend || (bus.clken && bus.sof))
        width_q <= cur_width;
      if (bus.clken) begin
        tap_p1 <= tap_pack;
        col_p1 <= cur_col;
        eol_p1 <= last;
        vld_p1 <= valid_nxt;
        if (last) begin
          wr_col   <= '0;
          row_fill <= (cur_fill == FULL) ? cur_fill : cur_fill + RFW'(1);
        end else begin
          wr_col   <= cur_col + AWIDTH'(1);
          row_fill <= cur_fill;
        end
      end
    end
  end

  assign bus.dout  = tap_p1;
  assign bus.col   = col_p1;
  assign bus.eol   = eol_p1;
  assign bus.valid = vld_p1;
endmodule
